// File: rtl/prometheus_fx3_pkt_gen.sv
// FX3 slave-FIFO test-pattern generator: stream, fixed-length short packet or ZLP
// traffic with an incrementing data word and a programmable inter-packet gap.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for enable + valid mode + in_rdy; latches mode/len/gap
// S_WAIT_RDY | waiting for the FX3 buffer to accept writes
// S_WRITE    | driving write strobes while out_rdy is high
// S_PKTEND   | one-cycle PKTEND strobe with no data (ZLP)
// S_WR_DELAY | one cycle after a packet/burst; bumps the packet counter
// S_GAP      | idle cycles before returning to S_IDLE
module prometheus_fx3_pkt_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 12,
  parameter int GAP_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_100,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic [1:0]            i_mode,
  input  logic [LEN_WIDTH-1:0]  i_pkt_len,
  input  logic [GAP_WIDTH-1:0]  i_gap,
  input  logic                  i_gpif_in_ch0_rdy_d,
  input  logic                  i_gpif_out_ch0_rdy_d,
  output logic                  o_gpif_we_n,
  output logic                  o_gpif_pkt_end_n,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CNT_WIDTH-1:0]  o_pkt_count,
  output logic                  o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_WRITE,
    S_PKTEND,
    S_WR_DELAY,
    S_GAP
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [GAP_WIDTH-1:0]  gap_q, gap_d;
  logic [LEN_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic                  we_n, pkt_end_n;

  logic is_stream, is_zlp, last_word, gap_done;

  // A short packet with zero length degenerates to a ZLP.
  assign is_stream = (mode_q == 2'd0);
  assign is_zlp    = (mode_q == 2'd2) || ((mode_q == 2'd1) && (len_q == '0));
  assign last_word = (word_cnt_q == (len_q - LEN_WIDTH'(1)));
  // Compare one bit wider so a gap of all-ones cannot wrap the test.
  assign gap_done  = (({1'b0, gap_cnt_q} + (GAP_WIDTH+1)'(1)) >= {1'b0, gap_q});

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    len_d      = len_q;
    gap_d      = gap_q;
    word_cnt_d = word_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    data_d     = data_q;
    pkt_cnt_d  = pkt_cnt_q;
    we_n       = 1'b1;
    pkt_end_n  = 1'b1;

    if (!i_enable) begin
      state_d    = S_IDLE;
      word_cnt_d = '0;
      gap_cnt_d  = '0;
      data_d     = '0;
      pkt_cnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          word_cnt_d = '0;
          gap_cnt_d  = '0;
          if ((i_mode != 2'd3) && i_gpif_in_ch0_rdy_d) begin
            state_d = S_WAIT_RDY;
            mode_d  = i_mode;
            len_d   = i_pkt_len;
            gap_d   = i_gap;
          end
        end
        S_WAIT_RDY: begin
          if (i_gpif_out_ch0_rdy_d) state_d = is_zlp ? S_PKTEND : S_WRITE;
        end
        S_WRITE: begin
          if (i_gpif_out_ch0_rdy_d) begin
            we_n       = 1'b0;
            data_d     = data_q + DATA_WIDTH'(1);
            word_cnt_d = word_cnt_q + LEN_WIDTH'(1);
            if (!is_stream && last_word) begin
              pkt_end_n  = 1'b0;
              word_cnt_d = '0;
              state_d    = S_WR_DELAY;
            end
          end else begin
            // Short packets pause and resume; a stream burst ends here.
            state_d = is_stream ? S_WR_DELAY : S_WAIT_RDY;
          end
        end
        S_PKTEND: begin
          pkt_end_n = 1'b0;
          state_d   = S_WR_DELAY;
        end
        S_WR_DELAY: begin
          pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
          state_d   = S_GAP;
        end
        S_GAP: begin
          gap_cnt_d = gap_cnt_q + GAP_WIDTH'(1);
          if (gap_done) begin
            gap_cnt_d = '0;
            state_d   = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= 2'd0;
      len_q      <= '0;
      gap_q      <= '0;
      word_cnt_q <= '0;
      gap_cnt_q  <= '0;
      data_q     <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      gap_q      <= gap_d;
      word_cnt_q <= word_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      data_q     <= data_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign o_gpif_we_n      = we_n;
  assign o_gpif_pkt_end_n = pkt_end_n;
  assign o_data           = data_q;
  assign o_pkt_count      = pkt_cnt_q;
  assign o_busy           = (state_q != S_IDLE);

endmodule

// File: doc/prometheus_fx3_pkt_gen.md
Name: prometheus_fx3_pkt_gen

Overview:
Parametrised FX3 slave-FIFO test-pattern generator. Supports three selectable traffic modes: continuous stream, fixed-length short packet, and zero-length packet (ZLP). It has a programmable packet length and a programmable inter-packet gap. It sits beside the slave-FIFO mux and drives GPIF write strobe, PKTEND and write data when its mode is selected.

Parameters:
DATA_WIDTH, 32, width of generated data word / GPIF data bus
LEN_WIDTH, 12, width of packet-length field (words)
GAP_WIDTH, 8, width of inter-packet gap field (cycles)
CNT_WIDTH, 16, width of packet counter

Ports:
clk_100  in  1  single system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
i_enable  in  1  generator enable; low aborts and clears
i_mode  in  2  0=stream, 1=short packet, 2=ZLP, 3=reserved (treated as disabled)
i_pkt_len  in  LEN_WIDTH  short-packet length in words
i_gap  in  GAP_WIDTH  idle cycles between packets
i_gpif_in_ch0_rdy_d  in  1  delayed FX3 "ready to start" flag
i_gpif_out_ch0_rdy_d  in  1  delayed FX3 "buffer can accept write" flag
o_gpif_we_n  out  1  active-low write strobe (combinational)
o_gpif_pkt_end_n  out  1  active-low packet end (combinational)
o_data  out  DATA_WIDTH  incrementing data word
o_pkt_count  out  CNT_WIDTH  packets/bursts completed, wraps
o_busy  out  1  high when state != IDLE

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE; o_data=0; o_pkt_count=0; word/gap counters=0. Outputs settle to o_gpif_we_n=1, o_gpif_pkt_end_n=1, o_busy=0.
- States: IDLE, WAIT_RDY, WRITE, PKTEND, WR_DELAY, GAP.
- IDLE:
  - Go to WAIT_RDY if i_enable, i_mode!=3 and i_gpif_in_ch0_rdy_d.
  - On that transition, latch mode, len and gap. Later input changes are ignored until the next IDLE.
  - Clear word counter.
- Effective mode: short mode with latched len==0 behaves as ZLP.
- WAIT_RDY: when i_gpif_out_ch0_rdy_d=1, go to PKTEND for ZLP, otherwise to WRITE. Hold while flag is 0.
- WRITE:
  - o_gpif_we_n=0 iff state==WRITE && i_gpif_out_ch0_rdy_d && i_enable.
  - Each write cycle increments o_data (by 1, wraps) and the word counter.
  - Stream: keep writing while the flag is 1. Flag 0 -> WR_DELAY (no pkt_end).
  - Short, flag 0 before last word: -> WAIT_RDY. Word counter is held, and writing resumes when the flag returns.
  - Short, last word: on the write cycle where word counter == len-1, assert o_gpif_pkt_end_n=0 in the same cycle as o_gpif_we_n=0, then go to WR_DELAY.
  - If the flag is 0 in that cycle, no write and no pkt_end occur.
- PKTEND (ZLP only): o_gpif_pkt_end_n=0 for exactly one cycle with o_gpif_we_n=1, then go to WR_DELAY.
- WR_DELAY: exactly one cycle; increment o_pkt_count; go to GAP.
- GAP:
  - Gap counter increments from 0 each cycle.
  - Exit to IDLE in the cycle the counter >= latched gap, so GAP lasts max(gap,1) cycles.
  - Gap counter clears on exit.
- Minimum ZLP period with gap=0: IDLE, WAIT_RDY, PKTEND, WR_DELAY, GAP = 5 cycles.
- i_enable=0:
  - o_gpif_we_n and o_gpif_pkt_end_n are forced to 1 combinationally.
  - Next state is IDLE from any state; a partial packet is abandoned with no pkt_end.
  - o_data, o_pkt_count and counters clear synchronously.
- rst overrides i_enable and all other inputs.
- o_pkt_count wraps from all-ones to 0.
- o_data wraps from all-ones to 0.
- PKTEND and WE are never both active outside the short-packet last-word cycle.

Test Plan:
- Reset, then rst=0, enable=1, mode=2, gap=0, both flags held 1 -> o_gpif_pkt_end_n low 1 cycle every 5 cycles. o_gpif_we_n stays 1, o_data stays 0, o_pkt_count = 1,2,3...
- Mode=1, len=4, gap=2, flags 1 -> 4 consecutive writes with o_data 0,1,2,3. pkt_end_n low with the write of word 3. Next packet starts with o_data=4 after GAP; o_pkt_count increments once per packet.
- Mode=1, len=6, out_rdy dropped for 3 cycles after the 2nd write -> writes pause, then resume at o_data=2. Exactly 6 writes total; pkt_end only on the 6th.
- Mode=0, out_rdy high 10 cycles then low -> 10 writes, o_data=10, no pkt_end, o_pkt_count=1 after WR_DELAY.
- Mode=1, len=0 -> identical to ZLP. Mode=1, len=1 -> single write with simultaneous pkt_end.
- Abort: enable dropped mid-WRITE in short mode, len=8, after 3 words -> we_n=1 the same cycle, no pkt_end, next cycle IDLE, o_data=0, o_pkt_count=0. Also assert rst mid-GAP -> all outputs at reset values next cycle.
